// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity encodings, FSM state codes and frame helpers shared by the UART blocks
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Bit periods in one frame: start, data, optional parity, stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with valid/ready write port and level
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // One extra pointer bit separates full from empty when the low bits match.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_fire;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ready = !full;
  assign wr_en    = wr_valid && !full;
  assign rd_fire  = rd_en && !empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign level    = LW'(wr_ptr - rd_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter: FIFO, baud divider, frame FSM and shifter
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 104,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [DATA_BITS-1:0]       wr_data,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  uart_state_t          state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 fifo_ready;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;

  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (fifo_ready),
    .rd_en    (pop),
    .rd_data  (head),
    .level    (level)
  );

  assign wr_ready = fifo_ready;
  assign bit_end  = (baud_cnt == '0);
  assign busy     = (state != ST_IDLE) || (level != '0);

  // A word leaves the FIFO either from idle or on the last stop-bit edge, so frames chain gap-free.
  always_comb begin
    pop = 1'b0;
    if (level != '0) begin
      if (state == ST_IDLE) begin
        pop = 1'b1;
      end else if ((state == ST_STOP) && bit_end && (stop_idx == STOP_LAST)) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= wr_valid && !fifo_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (state != ST_IDLE) begin
        baud_cnt <= bit_end ? BAUD_LAST : baud_cnt - CW'(1);
      end
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state    <= ST_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
      // Loading a new word overrides whatever the case above chose for this edge.
      if (pop) begin
        shift    <= head;
        par_bit  <= (^head) ^ (PARITY == PAR_ODD);
        baud_cnt <= BAUD_LAST;
        tx       <= 1'b0;
        state    <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - randomized check of uart_tx_buf in four configurations against a frame-timeline model
`timescale 1ns/1ps
module tb_uart_tx_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // field: 0 DATA_BITS, 1 PARITY, 2 STOP_BITS, 3 CLK_DIV, 4 DEPTH, 5 first directed word
  function automatic int cfg(input int i, input int field);
    case (i)
      0: case (field) 0: return 8; 1: return 0; 2: return 1; 3: return 4; 4: return 4; default: return 'h55; endcase
      1: case (field) 0: return 8; 1: return 1; 2: return 2; 3: return 4; 4: return 4; default: return 'h07; endcase
      2: case (field) 0: return 5; 1: return 2; 2: return 1; 3: return 2; 4: return 4; default: return 'h1F; endcase
      default: case (field) 0: return 9; 1: return 2; 2: return 2; 3: return 3; 4: return 8; default: return 'h03; endcase
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int DB  = cfg(g, 0);
    localparam int PAR = cfg(g, 1);
    localparam int SB  = cfg(g, 2);
    localparam int DIV = cfg(g, 3);
    localparam int DEP = cfg(g, 4);
    localparam int LW  = $clog2(DEP + 1);
    localparam int FC  = DIV * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

    logic          rst_n    = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DB-1:0] wr_data  = '0;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;
    logic          done = 1'b0;

    uart_tx_buf #(
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .CLK_DIV   (DIV),
      .DEPTH     (DEP)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .tx       (tx),
      .busy     (busy),
      .level    (level),
      .overflow (overflow)
    );

    // Model: queued words, the edge at which the line next becomes free, and the frame currently on the line.
    int          q[$];
    int          lvl     = 0;
    int          t       = 0;
    int          free_at = 0;
    int          fstart  = 0;
    logic [15:0] fbits   = '1;
    logic        ovf_e   = 1'b0;
    int          peak    = 0;
    int          ovf_cnt = 0;

    task automatic compare_outputs();
      logic tx_e;
      tx_e = 1'b1;
      if (t < free_at) tx_e = fbits[(t - fstart) / DIV];
      check($sformatf("g%0d tx t=%0d", g, t), tx, tx_e);
      check($sformatf("g%0d level t=%0d", g, t), level, lvl);
      check($sformatf("g%0d wr_ready t=%0d", g, t), wr_ready, lvl != DEP);
      check($sformatf("g%0d busy t=%0d", g, t), busy, (t < free_at) || (lvl > 0));
      check($sformatf("g%0d overflow t=%0d", g, t), overflow, ovf_e);
      if (int'(level) > peak) peak = int'(level);
      if (overflow) ovf_cnt++;
    endtask

    task automatic model_edge(input logic v, input logic [DB-1:0] d);
      logic full;
      logic acc;
      logic pop;
      int   w;
      int   ones;
      t++;
      full = (lvl == DEP);
      acc  = v && !full;
      pop  = (t >= free_at) && (lvl > 0);
      if (pop) begin
        w     = q.pop_front();
        ones  = $countones(w[DB-1:0]);
        fbits = '1;
        fbits[0] = 1'b0;
        for (int i = 0; i < DB; i++) fbits[1+i] = w[i];
        if (PAR == 1) fbits[1+DB] = ones[0];
        if (PAR == 2) fbits[1+DB] = !ones[0];
        fstart  = t;
        free_at = t + FC;
      end
      if (acc) q.push_back(int'(d));
      lvl   = lvl + int'(acc) - int'(pop);
      ovf_e = v && full;
    endtask

    task automatic step(input logic v, input logic [DB-1:0] d);
      @(negedge clk);
      compare_outputs();
      wr_valid = v;
      wr_data  = d;
      model_edge(v, d);
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      #1;
      check($sformatf("g%0d reset tx", g), tx, 1'b1);
      check($sformatf("g%0d reset level", g), level, 0);
      check($sformatf("g%0d reset busy", g), busy, 1'b0);
      check($sformatf("g%0d reset wr_ready", g), wr_ready, 1'b1);
      check($sformatf("g%0d reset overflow", g), overflow, 1'b0);
      q.delete();
      lvl = 0; t = 0; free_at = 0; fstart = 0; ovf_e = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_edge(1'b0, '0);
    endtask

    initial begin
      int dens;
      do_reset();
      step(1'b1, DB'(cfg(g, 5)));
      idle(FC + 5);
      // Two consecutive writes into an idle line chain frames with no gap.
      peak = 0;
      step(1'b1, DB'(32'hA5));
      step(1'b1, DB'(32'h3C));
      idle(2 * FC + 5);
      check($sformatf("g%0d pair peak level", g), peak, 1);
      // DEP+2 back-to-back writes: DEP+1 accepted, exactly one refused.
      peak = 0; ovf_cnt = 0;
      for (int i = 1; i <= DEP + 2; i++) step(1'b1, DB'(i));
      idle(3);
      check($sformatf("g%0d burst peak level", g), peak, DEP);
      check($sformatf("g%0d burst overflow pulses", g), ovf_cnt, 1);
      idle((DEP + 1) * FC + 5);
      step(1'b1, '0);
      idle(FC / 2);
      do_reset();
      step(1'b1, '1);
      idle(FC + 5);
      for (int blk = 0; blk < 6; blk++) begin
        dens = $urandom_range(5, 95);
        for (int i = 0; i < 100; i++) step($urandom_range(0, 99) < dens, DB'($urandom()));
      end
      for (int i = 0; i < (DEP + 2) * FC && !(lvl == 0 && t >= free_at); i++) step(1'b0, '0);
      idle(2);
      check($sformatf("g%0d drained busy", g), busy, 1'b0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 90000; i++) begin
      @(posedge clk);
      if (gen_dut[0].done && gen_dut[1].done && gen_dut[2].done && gen_dut[3].done) break;
    end
    check("all instances finished",
          {gen_dut[3].done, gen_dut[2].done, gen_dut[1].done, gen_dut[0].done}, 4'hF);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
